// File: rtl/i2s_tx_scheduler.sv
// i2s_tx_scheduler: I2S DAC clock generation and right-justified stereo serializer with one-entry sample buffer.
module i2s_tx_scheduler #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int SLOT_BITS    = 32,
  parameter int BCLK_HALF    = 4,
  parameter int MCLK_HALF    = 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    enable,
  input  logic [SAMPLE_WIDTH-1:0] sample_left,
  input  logic [SAMPLE_WIDTH-1:0] sample_right,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  output logic                    frame_start,
  output logic                    underrun,
  output logic [15:0]             underrun_count,
  output logic                    dac_sys_clk,
  output logic                    dac_bit_clk,
  output logic                    dac_lr_clk,
  output logic                    dac_data
);
  localparam int CW  = $clog2(2*BCLK_HALF);
  localparam int SLW = $clog2(2*SLOT_BITS);
  localparam int MW  = $clog2(MCLK_HALF+1);
  localparam int IW  = $clog2(SAMPLE_WIDTH);
  localparam logic [CW-1:0]  CNT_LAST  = CW'(2*BCLK_HALF-1);
  localparam logic [CW-1:0]  BH_L      = CW'(BCLK_HALF);
  localparam logic [SLW-1:0] SLOT_LAST = SLW'(2*SLOT_BITS-1);
  localparam logic [SLW-1:0] SB_L      = SLW'(SLOT_BITS);
  localparam logic [SLW-1:0] PAD       = SLW'(SLOT_BITS-SAMPLE_WIDTH);
  localparam logic [MW-1:0]  M_LAST    = MW'(MCLK_HALF-1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                  state, state_n;
  logic [CW-1:0]           cnt, cnt_n;
  logic [SLW-1:0]          slot, slot_n, half;
  logic [MW-1:0]           mcnt;
  logic [IW-1:0]           idx;
  logic [SAMPLE_WIDTH-1:0] buf_l, buf_r, sh_l, sh_r, ld_l, ld_r, src;
  logic                    wrap, fs, xfer, active_n;

  // Outputs are registered from the next position so they line up with the counters.
  always_comb begin
    wrap     = state == IDLE || (cnt == CNT_LAST && slot == SLOT_LAST);
    fs       = wrap && enable;
    xfer     = sample_valid && sample_ready;
    state_n  = enable ? RUN : wrap ? IDLE : DRAIN;
    cnt_n    = wrap || cnt == CNT_LAST ? '0 : cnt + 1'b1;
    slot_n   = wrap ? '0 : cnt == CNT_LAST ? slot + 1'b1 : slot;
    active_n = state_n != IDLE;
    ld_l     = sample_ready ? '0 : buf_l;
    ld_r     = sample_ready ? '0 : buf_r;
    src      = slot_n >= SB_L ? (fs ? ld_r : sh_r) : (fs ? ld_l : sh_l);
    half     = slot_n >= SB_L ? slot_n - SB_L : slot_n;
    idx      = half < PAD ? IW'(SAMPLE_WIDTH-1) : IW'(SB_L - 1'b1 - half);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= IDLE;
      cnt            <= '0;
      slot           <= '0;
      mcnt           <= '0;
      buf_l          <= '0;
      buf_r          <= '0;
      sh_l           <= '0;
      sh_r           <= '0;
      sample_ready   <= 1'b1;
      frame_start    <= 1'b0;
      underrun       <= 1'b0;
      underrun_count <= '0;
      dac_sys_clk    <= 1'b0;
      dac_bit_clk    <= 1'b0;
      dac_lr_clk     <= 1'b0;
      dac_data       <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      slot         <= slot_n;
      mcnt         <= mcnt == M_LAST ? '0 : mcnt + 1'b1;
      dac_sys_clk  <= mcnt == M_LAST ? ~dac_sys_clk : dac_sys_clk;
      frame_start  <= fs;
      underrun     <= fs && sample_ready;
      sample_ready <= xfer ? 1'b0 : sample_ready | fs;
      dac_bit_clk  <= active_n && cnt_n >= BH_L;
      dac_lr_clk   <= active_n && slot_n < SB_L;
      dac_data     <= active_n && src[idx];
      if (fs && sample_ready && underrun_count != 16'hFFFF)
        underrun_count <= underrun_count + 1'b1;
      if (fs) begin
        sh_l <= ld_l;
        sh_r <= ld_r;
      end
      if (xfer) begin
        buf_l <= sample_left;
        buf_r <= sample_right;
      end
    end
  end
endmodule

// File: tb/tb_i2s_tx_scheduler.sv
// tb_i2s_tx_scheduler: frame-time reference model with per-cycle compare, plus an I2S receiver for directed scenarios.
module tb_i2s_tx_scheduler;
  localparam int SW = 24, SB = 32, BH = 2, MH = 1;
  localparam int FL = 4*SB*BH, HL = FL/2;

  logic clk = 0, rstn = 1, enable = 0, sample_valid = 0, chk_on = 0;
  logic [SW-1:0] sample_left = '0, sample_right = '0;
  logic sample_ready, frame_start, underrun, dac_sys_clk, dac_bit_clk, dac_lr_clk, dac_data;
  logic [15:0] underrun_count;
  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  i2s_tx_scheduler #(.SAMPLE_WIDTH(SW), .SLOT_BITS(SB), .BCLK_HALF(BH), .MCLK_HALF(MH)) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .sample_left(sample_left), .sample_right(sample_right),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .frame_start(frame_start),
    .underrun(underrun), .underrun_count(underrun_count), .dac_sys_clk(dac_sys_clk),
    .dac_bit_clk(dac_bit_clk), .dac_lr_clk(dac_lr_clk), .dac_data(dac_data));

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sx(input logic [SW-1:0] v);
    return {{(32-SW){v[SW-1]}}, v};
  endfunction

  // Bit carried at frame time t: each half is the sign-extended sample, MSB of the slot word first.
  function automatic logic exp_bit(input int t, input logic [SW-1:0] l, input logic [SW-1:0] r);
    int slot, h, v;
    slot = t / (2*BH);
    h = slot % SB;
    v = slot < SB ? int'(sx(l)) : int'(sx(r));
    return logic'((v >>> (SB-1-h)) & 1);
  endfunction

  // Reference model: position in frame, FIFO-of-one buffer, shadow pair, counters.
  bit m_act, m_fs, m_ur, m_sys, m_xfer, m_go;
  int m_t, m_urc;
  logic [SW-1:0] m_l, m_r;
  logic [SW-1:0] q_l[$], q_r[$];

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_act = 0; m_t = 0; m_l = '0; m_r = '0; m_urc = 0; m_fs = 0; m_ur = 0; m_sys = 0;
      q_l.delete(); q_r.delete();
    end else begin
      m_xfer = sample_valid && q_l.size() == 0;
      m_go = !m_act || m_t == FL-1;
      m_fs = m_go && enable;
      m_ur = 0;
      if (m_go) begin
        m_act = enable;
        m_t = 0;
      end else m_t++;
      if (m_fs) begin
        if (q_l.size() > 0) begin
          m_l = q_l.pop_front();
          m_r = q_r.pop_front();
        end else begin
          m_l = '0; m_r = '0; m_ur = 1;
          if (m_urc < 65535) m_urc++;
        end
      end
      if (m_xfer) begin
        q_l.push_back(sample_left);
        q_r.push_back(sample_right);
      end
      m_sys = ~m_sys;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("sample_ready", sample_ready, q_l.size() == 0);
      chk("frame_start", frame_start, m_fs);
      chk("underrun", underrun, m_ur);
      chk("underrun_count", underrun_count, m_urc);
      chk("dac_sys_clk", dac_sys_clk, m_sys);
      chk("dac_bit_clk", dac_bit_clk, m_act && (m_t % (2*BH)) >= BH);
      chk("dac_lr_clk", dac_lr_clk, m_act && m_t < HL);
      chk("dac_data", dac_data, m_act && exp_bit(m_t, m_l, m_r));
    end
  end

  // Frame statistics observed on the pins.
  int cyc = 0, fs_cyc = 0, last_gap = 0, lr_acc = 0, last_lr = 0, fs_cnt = 0, ur_cnt = 0, sys_tog = 0;
  logic psys = 0;
  always @(negedge clk) begin
    if (frame_start) begin
      last_gap = cyc - fs_cyc;
      fs_cyc = cyc;
      last_lr = lr_acc;
      lr_acc = 0;
      fs_cnt++;
    end
    if (underrun) ur_cnt++;
    if (dac_lr_clk) lr_acc++;
    if (dac_sys_clk != psys) sys_tog++;
    psys = dac_sys_clk;
    cyc++;
  end

  // I2S receiver: shift on bit-clock rise, word keyed on lr.
  logic [31:0] rl = '0, rr = '0;
  logic [31:0] got_l[$], got_r[$], exp_l[$], exp_r[$];
  int rc = 0;
  logic plr = 0;
  always @(posedge dac_bit_clk or negedge rstn) begin
    if (!rstn) begin
      rc = 0; plr = 0;
    end else begin
      if (dac_lr_clk != plr) rc = 0;
      plr = dac_lr_clk;
      if (dac_lr_clk) rl = {rl[30:0], dac_data};
      else rr = {rr[30:0], dac_data};
      rc++;
      if (!dac_lr_clk && rc == SB) begin
        got_l.push_back(rl);
        got_r.push_back(rr);
      end
    end
  end

  task automatic supply(input logic [SW-1:0] l, input logic [SW-1:0] r);
    int n = 0;
    while (!sample_ready && n < 3*FL) begin
      @(negedge clk);
      n++;
    end
    if (!sample_ready) chk("supply_ready_timeout", 0, 1);
    sample_left = l; sample_right = r; sample_valid = 1;
    @(negedge clk);
    sample_valid = 0;
  endtask

  task automatic wait_fs();
    for (int n = 0; n < 3*FL; n++) begin
      @(negedge clk);
      if (frame_start) begin
        #1;
        return;
      end
    end
    chk("frame_start_timeout", 0, 1);
  endtask

  task automatic expect_frame(input logic [SW-1:0] l, input logic [SW-1:0] r);
    exp_l.push_back(sx(l));
    exp_r.push_back(sx(r));
  endtask

  task automatic chk_frames(input string tag);
    chk({tag, "_nframes"}, got_l.size(), exp_l.size());
    for (int i = 0; i < got_l.size() && i < exp_l.size(); i++) begin
      chk({tag, "_left"}, got_l[i], exp_l[i]);
      chk({tag, "_right"}, got_r[i], exp_r[i]);
    end
    got_l.delete(); got_r.delete(); exp_l.delete(); exp_r.delete();
  endtask

  initial begin
    int t0, f0, u0;
    logic [31:0] a;
    #1 rstn = 0;
    chk_on = 1;
    repeat (3) @(negedge clk);
    chk("reset_ready", sample_ready, 1);
    chk("reset_urc", underrun_count, 0);
    chk("reset_lr", dac_lr_clk, 0);
    rstn = 1;

    // Idle: only the master clock runs.
    t0 = sys_tog;
    repeat (100) @(negedge clk);
    #1;
    chk("idle_sys_toggles", sys_tog - t0, 100);
    chk("idle_frames", fs_cnt, 0);
    chk("idle_bclk", dac_bit_clk, 0);

    // Single frame then a second, draining mid-frame.
    got_l.delete(); got_r.delete();
    supply(24'h800001, 24'h7FFFFF);
    expect_frame(24'h800001, 24'h7FFFFF);
    enable = 1;
    wait_fs();
    supply(24'h000001, 24'hFFFFFE);
    expect_frame(24'h000001, 24'hFFFFFE);
    wait_fs();
    chk("frame_len", last_gap, 256);
    chk("lr_high_cycles", last_lr, 128);
    repeat (HL/2) @(negedge clk);
    enable = 0;
    repeat (FL) @(negedge clk);
    #1;
    chk("drain_lr", dac_lr_clk, 0);
    chk("drain_bclk", dac_bit_clk, 0);
    chk("drain_data", dac_data, 0);
    chk("drain_frames", fs_cnt, 2);
    a = got_l.size() > 0 ? got_l[0] : 32'd0;
    chk("left_recovered", $signed(a), -8388607);
    a = got_r.size() > 0 ? got_r[0] : 32'd0;
    chk("right_recovered", $signed(a), 8388607);
    chk_frames("single");

    // Streaming: a new pair shortly after every frame start.
    f0 = fs_cnt;
    supply(24'd1000, 24'd5000);
    expect_frame(24'd1000, 24'd5000);
    enable = 1;
    for (int k = 1; k <= 20; k++) begin
      wait_fs();
      repeat (10) @(negedge clk);
      supply(24'(1000 + k), 24'(5000 + k));
      if (k < 20) expect_frame(24'(1000 + k), 24'(5000 + k));
    end
    enable = 0;
    repeat (FL + 20) @(negedge clk);
    #1;
    chk("stream_urc", underrun_count, 0);
    chk("stream_frames", fs_cnt - f0, 20);
    chk_frames("stream");

    // Underrun: the buffered pair plays, then one starved frame, then a late pair.
    u0 = ur_cnt;
    expect_frame(24'd1020, 24'd5020);
    enable = 1;
    wait_fs();
    wait_fs();
    chk("underrun_pulse", underrun, 1);
    expect_frame(24'd0, 24'd0);
    supply(24'hABCDEF, 24'h123456);
    expect_frame(24'hABCDEF, 24'h123456);
    wait_fs();
    repeat (50) @(negedge clk);
    enable = 0;
    repeat (FL + 20) @(negedge clk);
    #1;
    chk("underrun_count", underrun_count, 1);
    chk("underrun_pulses", ur_cnt - u0, 1);
    chk_frames("underrun");

    // Asynchronous reset at slot 40, then a clean restart.
    supply(24'h555555, 24'hAAAAAA);
    enable = 1;
    wait_fs();
    repeat (40*2*BH) @(negedge clk);
    #2 rstn = 0;
    #1;
    chk("rst_bclk", dac_bit_clk, 0);
    chk("rst_lr", dac_lr_clk, 0);
    chk("rst_data", dac_data, 0);
    chk("rst_sys", dac_sys_clk, 0);
    chk("rst_ready", sample_ready, 1);
    chk("rst_urc", underrun_count, 0);
    enable = 0;
    repeat (3) @(negedge clk);
    rstn = 1;
    got_l.delete(); got_r.delete(); exp_l.delete(); exp_r.delete();
    supply(24'h0F0F0F, 24'hF0F0F0);
    expect_frame(24'h0F0F0F, 24'hF0F0F0);
    enable = 1;
    wait_fs();
    repeat (20) @(negedge clk);
    enable = 0;
    repeat (FL + 20) @(negedge clk);
    #1;
    chk("restart_urc", underrun_count, 0);
    chk_frames("restart");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
